// File: rtl/track_segment_arbiter.sv
// ---------------------------------------------------------------------------
// track_segment_arbiter
//
// Grants a single shared track segment to one of two trains (A or B).
// A request in IDLE selects the route and moves the switch bank first. The
// grant is issued after the switch bank has been held for SETTLE cycles. The
// owner keeps the segment until the exit sensor (CLR) fires. When both trains
// ask at the same time, the train that was not served last wins. The LAST
// pointer resets to A, so B wins the first tie.
//
// Optional feature (macro TRACK_ARB_WATCHDOG_EN):
//   When defined, the shared counter also times the occupancy. If TIMEOUT
//   cycles pass without CLR, the FSM enters a sticky FAULT state, and only
//   RESET leaves it. When undefined, FAULT is tied low and occupancy is
//   unbounded.
//
// Parameters:
//   SETTLE   switch-bank hold cycles before a grant (1 .. 2^CNT_W-1)
//   TIMEOUT  occupancy limit in cycles (watchdog builds only)
//   CNT_W    width of the shared settle/occupancy counter
//
// Ports:
//   Clock      rising-edge clock
//   RESET      synchronous, active-high reset
//   REQ_A      train A waiting at the entry sensor (level)
//   REQ_B      train B waiting at the entry sensor (level)
//   CLR        exit sensor, the granted train has left
//   SW         switch bank: 3'b000 = route A, 3'b011 = route B
//   DA, DB     train drive: 2'b01 = go, 2'b00 = stop
//   GRANT_A/B  segment owned by A / B
//   FAULT      watchdog tripped
//   dbg_state  current FSM state code (for observation only)
//
// All functional outputs are registered. They are decoded from the next
// state, so they change on the same edge as the state register (Moore).
// ---------------------------------------------------------------------------
module track_segment_arbiter #(
    parameter int SETTLE  = 4,
    parameter int TIMEOUT = 200,
    parameter int CNT_W   = 8
) (
    input  logic       Clock,
    input  logic       RESET,
    input  logic       REQ_A,
    input  logic       REQ_B,
    input  logic       CLR,
    output logic [2:0] SW,
    output logic [1:0] DA,
    output logic [1:0] DB,
    output logic       GRANT_A,
    output logic       GRANT_B,
    output logic       FAULT,
    output logic [2:0] dbg_state
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SET_A = 3'd1,
        ST_OCC_A = 3'd2,
        ST_SET_B = 3'd3,
        ST_OCC_B = 3'd4
`ifdef TRACK_ARB_WATCHDOG_EN
        , ST_FAULT = 3'd5
`endif
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX     = '1;
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE - 1);
`ifdef TRACK_ARB_WATCHDOG_EN
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT - 1);
`endif

    // Both limits must be reachable by the counter, or the FSM would never
    // leave SET_x (or never time out).
    if (SETTLE < 1 || SETTLE > (1 << CNT_W) - 1) begin : g_bad_settle
        $error("track_segment_arbiter: SETTLE out of range");
    end
    if (TIMEOUT < 1 || TIMEOUT > (1 << CNT_W) - 1) begin : g_bad_timeout
        $error("track_segment_arbiter: TIMEOUT out of range");
    end

    state_t           state, state_nx;
    logic [CNT_W-1:0] cnt, cnt_nx, cnt_inc;
    logic             last_b, last_b_nx;   // 1: B was served last
    logic [2:0]       sw_nx;
    logic [1:0]       da_nx, db_nx;
    logic             ga_nx, gb_nx;

    assign dbg_state = state;

    // Next-state and counter logic.
    always_comb begin
        state_nx  = state;
        cnt_nx    = cnt;
        last_b_nx = last_b;
        // The counter saturates instead of wrapping.
        cnt_inc   = (cnt == CNT_MAX) ? cnt : cnt + 1'b1;
        case (state)
            ST_IDLE: begin
                cnt_nx = '0;
                if (REQ_A && REQ_B) begin
                    state_nx = last_b ? ST_SET_A : ST_SET_B;
                end else if (REQ_A) begin
                    state_nx = ST_SET_A;
                end else if (REQ_B) begin
                    state_nx = ST_SET_B;
                end
            end
            // CLR and request withdrawal are deliberately not looked at
            // here. Once the switch bank starts moving, the grant completes.
            ST_SET_A, ST_SET_B: begin
                if (cnt == SETTLE_LAST) begin
                    state_nx = (state == ST_SET_A) ? ST_OCC_A : ST_OCC_B;
                    cnt_nx   = '0;
                end else begin
                    cnt_nx = cnt_inc;
                end
            end
            ST_OCC_A, ST_OCC_B: begin
                // CLR wins over a timeout in the same cycle.
                if (CLR) begin
                    state_nx  = ST_IDLE;
                    last_b_nx = (state == ST_OCC_B);
                    cnt_nx    = '0;
                end
`ifdef TRACK_ARB_WATCHDOG_EN
                else if (cnt == TIMEOUT_LAST) begin
                    state_nx = ST_FAULT;
                end else begin
                    cnt_nx = cnt_inc;
                end
`endif
            end
`ifdef TRACK_ARB_WATCHDOG_EN
            ST_FAULT: state_nx = ST_FAULT;
`endif
            default: begin
                state_nx = ST_IDLE;
                cnt_nx   = '0;
            end
        endcase
    end

    // Output decode from the next state. SW holds in IDLE/FAULT.
    always_comb begin
        sw_nx = SW;
        da_nx = 2'b00;
        db_nx = 2'b00;
        ga_nx = 1'b0;
        gb_nx = 1'b0;
        case (state_nx)
            ST_SET_A: sw_nx = 3'b000;
            ST_SET_B: sw_nx = 3'b011;
            ST_OCC_A: begin
                sw_nx = 3'b000;
                da_nx = 2'b01;
                ga_nx = 1'b1;
            end
            ST_OCC_B: begin
                sw_nx = 3'b011;
                db_nx = 2'b01;
                gb_nx = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (RESET) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            last_b  <= 1'b0;
            SW      <= 3'b011;
            DA      <= 2'b00;
            DB      <= 2'b00;
            GRANT_A <= 1'b0;
            GRANT_B <= 1'b0;
        end else begin
            state   <= state_nx;
            cnt     <= cnt_nx;
            last_b  <= last_b_nx;
            SW      <= sw_nx;
            DA      <= da_nx;
            DB      <= db_nx;
            GRANT_A <= ga_nx;
            GRANT_B <= gb_nx;
        end
    end

`ifdef TRACK_ARB_WATCHDOG_EN
    always_ff @(posedge Clock) begin
        if (RESET) begin
            FAULT <= 1'b0;
        end else begin
            FAULT <= (state_nx == ST_FAULT);
        end
    end
`else
    assign FAULT = 1'b0;
`endif

endmodule
